compare_stats_2bit: RTL and testbench
=====================================

COMPARE_STATS_2BIT -- requirements
Module: compare_stats_2bit

Interface
REQ-001 Parameter MAX_FRAME, default 8: maximum number of samples in a frame; legal range 1..255.
REQ-002 Derived constant CNT_W = $clog2(MAX_FRAME+1): width of every count output.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  sample pair valid.
REQ-006 in_ready  output  1  block accepts a sample pair this cycle.
REQ-007 in_a  input  2  operand A, unsigned.
REQ-008 in_b  input  2  operand B, unsigned.
REQ-009 in_last  input  1  final sample of the current frame.
REQ-010 out_valid  output  1  frame statistics valid.
REQ-011 out_ready  input  1  downstream accepts statistics.
REQ-012 gt_cnt  output  CNT_W  number of frame samples with A>B.
REQ-013 eq_cnt  output  CNT_W  number of frame samples with A==B.
REQ-014 lt_cnt  output  CNT_W  number of frame samples with A<B.
REQ-015 frame_len  output  CNT_W  number of samples in the frame (always gt_cnt+eq_cnt+lt_cnt).
REQ-016 max_a  output  2  largest in_a seen in the frame.

Function
REQ-017 A sample is accepted exactly when in_valid && in_ready are both high on a rising edge.
REQ-018 FSM states: IDLE (no samples in frame), ACCUM (at least one sample taken), REPORT (statistics presented).
REQ-019 in_ready is 1 in IDLE and ACCUM and 0 in REPORT; it has no combinational dependency on in_valid.
REQ-020 Each accepted sample increments exactly one of gt/eq/lt counts, selected by unsigned comparison of in_a against in_b.
REQ-021 Each accepted sample increments frame_len by 1 and updates max_a to the larger of max_a and in_a; the first sample of a frame loads max_a directly.
REQ-022 IDLE -> ACCUM on acceptance of a sample with in_last=0 and frame_len+1 < MAX_FRAME.
REQ-023 IDLE or ACCUM -> REPORT on acceptance of a sample with in_last=1, or of the sample that makes frame_len equal MAX_FRAME (forced close; in_last is ignored in that case).
REQ-024 out_valid is 1 exactly in REPORT, asserted the cycle after the closing sample is accepted; latency from closing sample to out_valid is 1 cycle.
REQ-025 All statistics outputs are registered, include the closing sample, and remain stable while out_valid=1 && out_ready=0.
REQ-026 REPORT -> IDLE on out_valid && out_ready; counts, frame_len and max_a clear to 0 on that same edge; in_ready returns to 1 the following cycle (one-cycle bubble per frame).
REQ-027 in_valid is ignored in REPORT; samples are never dropped or counted twice.
REQ-028 Counts cannot overflow: a forced close at MAX_FRAME bounds every count at MAX_FRAME.
REQ-029 Statistics outputs read 0 when out_valid=0 only after reset or a completed report; they hold the running values during ACCUM.

Reset
REQ-030 On a rising edge with rst_n=0: state IDLE, out_valid=0, all counts, frame_len and max_a 0, in_ready 1 from the first edge after rst_n rises.
REQ-031 Reset asserted mid-frame or in REPORT discards the partial or pending frame without emitting it.

Structure
REQ-032 The state enum (IDLE, ACCUM, REPORT) and the default MAX_FRAME constant live in a shared package, cmp_pkg.
REQ-033 The A/B ordering decision comes from one instance of the team's existing comparator_2bit; its gt/eq/lt flags drive the count enables, and no second comparison of in_a against in_b is coded.
REQ-034 A second comparator_2bit instance compares in_a against max_a to drive the max update.

Verification
REQ-035 Frame (3,2),(1,1),(0,3) with last on the third sample -> one cycle later out_valid=1, gt=1, eq=1, lt=1, frame_len=3, max_a=3.
REQ-036 9 samples of (2,2) with no in_last, MAX_FRAME=8 -> report eq=8, frame_len=8; the 9th sample is counted in the next frame (eq=1).
REQ-037 out_ready held 0 for 5 cycles in REPORT -> outputs stable, in_ready=0, in_valid pulses not counted; after out_ready=1, in_ready=1 the next cycle.
REQ-038 Single-sample frame (0,1,last=1) -> lt=1, frame_len=1, max_a=0.
REQ-039 rst_n=0 for one cycle after 2 samples mid-frame -> no report; next frame (1,0,last) reports gt=1, frame_len=1.
REQ-040 Back-to-back frames with out_ready tied 1 -> every frame reported once with correct counts and exactly one idle cycle of in_ready between frames.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared definitions for the frame comparison statistics block.
package cmp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam int MAX_FRAME_DEF = 8;

endpackage

// File: rtl/comparator_2bit.sv
// Unsigned 2-bit magnitude comparator; exactly one flag is high.
module comparator_2bit (
    input  logic [1:0] a_i,
    input  logic [1:0] b_i,
    output logic       gt_o,
    output logic       eq_o,
    output logic       lt_o
);

    assign gt_o = (a_i > b_i);
    assign eq_o = (a_i == b_i);
    assign lt_o = (a_i < b_i);

endmodule

// File: rtl/compare_stats_2bit.sv
// Accumulates per-frame A/B ordering counts and max(A), then holds them
// behind a valid/ready report until downstream takes them.
module compare_stats_2bit
    import cmp_pkg::*;
#(
    parameter  int MAX_FRAME = MAX_FRAME_DEF,
    localparam int CNT_W     = $clog2(MAX_FRAME + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_a,
    input  logic [1:0]       in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] gt_cnt,
    output logic [CNT_W-1:0] eq_cnt,
    output logic [CNT_W-1:0] lt_cnt,
    output logic [CNT_W-1:0] frame_len,
    output logic [1:0]       max_a
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_FRAME);

    state_e           state_q;
    logic             in_ready_q, out_valid_q;
    logic [CNT_W-1:0] gt_q, eq_q, lt_q, len_q;
    logic [1:0]       max_q;

    logic             a_gt_b, a_eq_b, a_lt_b;
    logic             a_gt_max, a_eq_max, a_lt_max;
    logic             accept, close;
    logic [CNT_W-1:0] len_d;
    logic [1:0]       max_d;
    logic             max_cmp_unused;

    comparator_2bit u_cmp_ab (
        .a_i  (in_a),
        .b_i  (in_b),
        .gt_o (a_gt_b),
        .eq_o (a_eq_b),
        .lt_o (a_lt_b)
    );

    comparator_2bit u_cmp_max (
        .a_i  (in_a),
        .b_i  (max_q),
        .gt_o (a_gt_max),
        .eq_o (a_eq_max),
        .lt_o (a_lt_max)
    );

    assign max_cmp_unused = a_eq_max ^ a_lt_max;

    assign accept = in_valid && in_ready_q;
    assign len_d  = len_q + CNT_W'(1);
    // A full frame closes on its own; in_last is irrelevant at that point.
    assign close  = in_last || (len_d == MAX_CNT);
    assign max_d  = (state_q == IDLE || a_gt_max) ? in_a : max_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            gt_q        <= '0;
            eq_q        <= '0;
            lt_q        <= '0;
            len_q       <= '0;
            max_q       <= '0;
        end else begin
            case (state_q)
                IDLE, ACCUM: begin
                    if (accept) begin
                        gt_q  <= gt_q + CNT_W'(a_gt_b);
                        eq_q  <= eq_q + CNT_W'(a_eq_b);
                        lt_q  <= lt_q + CNT_W'(a_lt_b);
                        len_q <= len_d;
                        max_q <= max_d;
                        if (close) begin
                            state_q     <= REPORT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end else begin
                            state_q <= ACCUM;
                        end
                    end
                end
                REPORT: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                        out_valid_q <= 1'b0;
                        gt_q        <= '0;
                        eq_q        <= '0;
                        lt_q        <= '0;
                        len_q       <= '0;
                        max_q       <= '0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign gt_cnt    = gt_q;
    assign eq_cnt    = eq_q;
    assign lt_cnt    = lt_q;
    assign frame_len = len_q;
    assign max_a     = max_q;

endmodule

// File: tb/tb_compare_stats_2bit.sv
// Random-stimulus bench: a queue holds the open frame and every output is
// recomputed from it by counting, then compared once per cycle.
module tb_compare_stats_2bit;

    localparam int MAXF  = 8;
    localparam int CNT_W = $clog2(MAXF + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid, in_last, out_ready;
    logic [1:0]       in_a, in_b;
    logic             in_ready, out_valid;
    logic [CNT_W-1:0] gt_cnt, eq_cnt, lt_cnt, frame_len;
    logic [1:0]       max_a;

    compare_stats_2bit #(.MAX_FRAME(MAXF)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .gt_cnt    (gt_cnt),
        .eq_cnt    (eq_cnt),
        .lt_cnt    (lt_cnt),
        .frame_len (frame_len),
        .max_a     (max_a)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rep  = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    // Reference: samples accepted into the open (or reported) frame.
    int  fa[$];
    int  fb[$];
    bit  m_rep;

    task automatic check_outputs();
        int g, e, l, mx;
        g = 0; e = 0; l = 0; mx = 0;
        foreach (fa[i]) begin
            if (fa[i] > fb[i]) g++;
            else if (fa[i] == fb[i]) e++;
            else l++;
            if (fa[i] > mx) mx = fa[i];
        end
        chk("in_ready",  int'(in_ready),  int'(!m_rep));
        chk("out_valid", int'(out_valid), int'(m_rep));
        chk("gt_cnt",    int'(gt_cnt),    g);
        chk("eq_cnt",    int'(eq_cnt),    e);
        chk("lt_cnt",    int'(lt_cnt),    l);
        chk("frame_len", int'(frame_len), fa.size());
        chk("max_a",     int'(max_a),     mx);
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            fa.delete(); fb.delete(); m_rep = 0;
        end else if (m_rep) begin
            if (out_ready) begin
                fa.delete(); fb.delete(); m_rep = 0; n_rep++;
            end
        end else if (in_valid) begin
            fa.push_back(int'(in_a));
            fb.push_back(int'(in_b));
            if (in_last || fa.size() == MAXF) m_rep = 1;
        end
    endtask

    // Phase knobs: percent chances of valid, last, out_ready, reset.
    task automatic drive(input int pv, input int pl, input int pr, input int prst);
        rst_n     = ($urandom_range(99) >= prst);
        in_valid  = ($urandom_range(99) < pv);
        in_last   = ($urandom_range(99) < pl);
        out_ready = ($urandom_range(99) < pr);
        in_a      = 2'($urandom_range(3));
        in_b      = 2'($urandom_range(3));
    endtask

    task automatic run_phase(input int cycles, input int pv, input int pl,
                             input int pr, input int prst);
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            check_outputs();
            @(posedge clk);
            model_edge();
            #1;
            drive(pv, pl, pr, prst);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_last = 1'b0; out_ready = 1'b0;
        in_a = 2'd3; in_b = 2'd0;
        m_rep = 0;
        repeat (2) @(posedge clk);
        #1;
        drive(70, 20, 60, 0);
        run_phase(600, 70, 20, 60, 0);   // mixed traffic
        run_phase(400, 100, 0, 100, 0);  // only forced closes, back-to-back
        run_phase(400, 80, 30, 15, 0);   // long stalls in REPORT
        run_phase(300, 60, 5, 50, 4);    // reset dropped in at random
        run_phase(200, 100, 50, 100, 0); // short frames, always drained
        if (n_rep < 20) chk("reports_seen", n_rep, 20);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

endmodule
